// File: rtl/ucie_pkg.sv
// Shared UCIe PHY training types: command encodings, responder states and status bit indices.
package ucie_pkg;

    typedef enum logic [7:0] {
        PHY_CMD_NONE     = 8'h00,
        PHY_CMD_SBINIT   = 8'h01,
        PHY_CMD_MBINIT   = 8'h02,
        PHY_CMD_CAL      = 8'h03,
        PHY_CMD_TRAIN    = 8'h04,
        PHY_CMD_LINKINIT = 8'h05,
        PHY_CMD_REPAIR   = 8'h06
    } phy_train_cmd_e;

    typedef enum logic [1:0] {
        PHY_RESP_RESET = 2'd0,
        PHY_RESP_IDLE  = 2'd1,
        PHY_RESP_RUN   = 2'd2,
        PHY_RESP_DONE  = 2'd3
    } phy_resp_state_e;

    localparam int PHY_STS_MB_RDY      = 0;
    localparam int PHY_STS_CAL_DONE    = 1;
    localparam int PHY_STS_TRAIN_DONE  = 2;
    localparam int PHY_STS_LINK_RDY    = 3;
    localparam int PHY_STS_REPAIR_DONE = 4;
    localparam int PHY_STS_REPAIR_FAIL = 5;
    localparam int PHY_STS_STALL_TO    = 6;
    localparam int PHY_STS_BUSY        = 7;

    // Status bits [6:0] invalidated when a step starts: a step voids its own result and every
    // later bring-up stage that depended on it; a stale stall timeout is always dropped.
    function automatic logic [6:0] phy_entry_clear(input logic [7:0] cmd);
        logic [6:0] mask;
        mask = 7'b100_0000;
        case (cmd)
            PHY_CMD_MBINIT:   mask = 7'b100_1111;
            PHY_CMD_CAL:      mask = 7'b100_1110;
            PHY_CMD_TRAIN:    mask = 7'b100_1100;
            PHY_CMD_LINKINIT: mask = 7'b100_1000;
            PHY_CMD_REPAIR:   mask = 7'b111_0000;
            default:          mask = 7'b100_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ucie_lane_repair_calc.sv
// Combinational lane-repair evaluation: which in-use lanes newly failed and whether the repair budget covers them.
module ucie_lane_repair_calc #(
    parameter int NUM_LANES  = 16,
    parameter int MAX_REPAIR = 2
) (
    input  logic [NUM_LANES-1:0]         lane_error,
    input  logic [NUM_LANES-1:0]         lane_map,
    output logic [NUM_LANES-1:0]         newly_failed,
    output logic [$clog2(NUM_LANES+1)-1:0] fail_count,
    output logic                         pass
);

    localparam int CNT_W = $clog2(NUM_LANES + 1);

    always_comb begin
        newly_failed = lane_error & lane_map;
        fail_count   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            fail_count = fail_count + CNT_W'(newly_failed[i]);
        end
        pass = (int'(fail_count) <= MAX_REPAIR);
    end

endmodule

// File: rtl/ucie_phy_train_responder.sv
// PHY training responder: decodes adapter commands, times each training step and reports status.
// Optional feature macro: UCIE_PHY_RESP_STALL_LIMIT_EN (abort a step after STALL_LIMIT busy cycles).
module ucie_phy_train_responder
    import ucie_pkg::*;
#(
    parameter int NUM_LANES       = 16,
    parameter int TIMER_W         = 16,
    parameter int SBINIT_CYCLES   = 64,
    parameter int MBINIT_CYCLES   = 32,
    parameter int CAL_CYCLES      = 256,
    parameter int TRAIN_CYCLES    = 1024,
    parameter int LINKINIT_CYCLES = 32,
    parameter int REPAIR_CYCLES   = 512,
    parameter int MAX_REPAIR      = 2,
    parameter int STALL_LIMIT     = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 phy_reset_req,
    output logic                 phy_reset_ack,
    input  logic [7:0]           phy_train_cmd,
    output logic [7:0]           phy_train_status,
    input  logic                 analog_busy,
    input  logic [NUM_LANES-1:0] lane_error,
    output logic [NUM_LANES-1:0] lane_map,
    output logic [1:0]           resp_state,
    output logic                 cmd_err
);

    localparam int CNT_W = $clog2(NUM_LANES + 1);

    phy_resp_state_e      state;
    phy_train_cmd_e       run_cmd;
    logic [7:0]           cmd_q;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   dur_m1;
    logic [6:0]           sts;
    logic [NUM_LANES-1:0] err_q;
    logic [NUM_LANES-1:0] newly_failed;
    logic [CNT_W-1:0]     fail_count;
    logic                 repair_pass;
    logic                 cmd_legal;
    logic                 new_cmd;
`ifdef UCIE_PHY_RESP_STALL_LIMIT_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    logic [STALL_W-1:0]   stall_cnt;
`endif

    ucie_lane_repair_calc #(
        .NUM_LANES  (NUM_LANES),
        .MAX_REPAIR (MAX_REPAIR)
    ) u_repair_calc (
        .lane_error   (err_q),
        .lane_map     (lane_map),
        .newly_failed (newly_failed),
        .fail_count   (fail_count),
        .pass         (repair_pass)
    );

    assign cmd_legal = (phy_train_cmd >= 8'h01) && (phy_train_cmd <= 8'h06);
    assign new_cmd   = cmd_legal && (phy_train_cmd != cmd_q);

    // NOTE: every variable written in always_comb gets a default first, or a latch is inferred.
    always_comb begin
        dur_m1 = TIMER_W'(SBINIT_CYCLES - 1);
        case (run_cmd)
            PHY_CMD_MBINIT:   dur_m1 = TIMER_W'(MBINIT_CYCLES - 1);
            PHY_CMD_CAL:      dur_m1 = TIMER_W'(CAL_CYCLES - 1);
            PHY_CMD_TRAIN:    dur_m1 = TIMER_W'(TRAIN_CYCLES - 1);
            PHY_CMD_LINKINIT: dur_m1 = TIMER_W'(LINKINIT_CYCLES - 1);
            PHY_CMD_REPAIR:   dur_m1 = TIMER_W'(REPAIR_CYCLES - 1);
            default:          dur_m1 = TIMER_W'(SBINIT_CYCLES - 1);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= PHY_RESP_RESET;
            run_cmd       <= PHY_CMD_NONE;
            cmd_q         <= '0;
            timer         <= '0;
            sts           <= '0;
            err_q         <= '0;
            lane_map      <= '1;
            phy_reset_ack <= 1'b0;
            cmd_err       <= 1'b0;
`ifdef UCIE_PHY_RESP_STALL_LIMIT_EN
            stall_cnt     <= '0;
`endif
        end else begin
            if (phy_train_cmd > 8'h06) cmd_err <= 1'b1;

            if (phy_reset_req) begin
                state         <= PHY_RESP_RESET;
                cmd_q         <= '0;
                timer         <= '0;
                sts           <= '0;
                lane_map      <= '1;
                phy_reset_ack <= 1'b0;
`ifdef UCIE_PHY_RESP_STALL_LIMIT_EN
                stall_cnt     <= '0;
`endif
            end else if (state == PHY_RESP_RESET) begin
                state <= PHY_RESP_IDLE;
            end else begin
                cmd_q <= phy_train_cmd;
                if (new_cmd) begin
                    // Start (or abort and restart) a step on the new command.
                    state   <= PHY_RESP_RUN;
                    run_cmd <= phy_train_cmd_e'(phy_train_cmd);
                    timer   <= '0;
                    sts     <= sts & ~phy_entry_clear(phy_train_cmd);
                    if (phy_train_cmd == PHY_CMD_SBINIT) phy_reset_ack <= 1'b0;
                    if (phy_train_cmd == PHY_CMD_REPAIR) err_q <= lane_error;
`ifdef UCIE_PHY_RESP_STALL_LIMIT_EN
                    stall_cnt <= '0;
`endif
                end else if (phy_train_cmd == PHY_CMD_NONE) begin
                    if (state != PHY_RESP_IDLE) state <= PHY_RESP_IDLE;
                end else if (state == PHY_RESP_RUN) begin
                    if (!analog_busy) begin
`ifdef UCIE_PHY_RESP_STALL_LIMIT_EN
                        stall_cnt <= '0;
`endif
                        if (timer == dur_m1) begin
                            state <= PHY_RESP_DONE;
                            case (run_cmd)
                                PHY_CMD_SBINIT:   phy_reset_ack <= 1'b1;
                                PHY_CMD_MBINIT:   sts[PHY_STS_MB_RDY]     <= 1'b1;
                                PHY_CMD_CAL:      sts[PHY_STS_CAL_DONE]   <= 1'b1;
                                PHY_CMD_TRAIN:    sts[PHY_STS_TRAIN_DONE] <= 1'b1;
                                PHY_CMD_LINKINIT: sts[PHY_STS_LINK_RDY]   <= 1'b1;
                                PHY_CMD_REPAIR: begin
                                    if (repair_pass) begin
                                        lane_map                 <= lane_map & ~newly_failed;
                                        sts[PHY_STS_REPAIR_DONE] <= 1'b1;
                                    end else begin
                                        sts[PHY_STS_REPAIR_FAIL] <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
`ifdef UCIE_PHY_RESP_STALL_LIMIT_EN
                    else if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) begin
                        sts[PHY_STS_STALL_TO] <= 1'b1;
                        state                 <= PHY_RESP_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
            end
        end
    end

    assign phy_train_status = {state == PHY_RESP_RUN, sts};
    assign resp_state       = state;

endmodule

// File: tb/tb_ucie_phy_train_responder.sv
// Directed self-checking bench for ucie_phy_train_responder with shortened step durations.
module tb_ucie_phy_train_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       phy_reset_req;
    logic       phy_reset_ack;
    logic [7:0] phy_train_cmd;
    logic [7:0] phy_train_status;
    logic       analog_busy;
    logic [7:0] lane_error;
    logic [7:0] lane_map;
    logic [1:0] resp_state;
    logic       cmd_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_RESET = 2'd0, S_IDLE = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;

    ucie_phy_train_responder #(
        .NUM_LANES       (8),
        .TIMER_W         (16),
        .SBINIT_CYCLES   (4),
        .MBINIT_CYCLES   (3),
        .CAL_CYCLES      (5),
        .TRAIN_CYCLES    (6),
        .LINKINIT_CYCLES (2),
        .REPAIR_CYCLES   (4),
        .MAX_REPAIR      (2),
        .STALL_LIMIT     (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phy_reset_req    (phy_reset_req),
        .phy_reset_ack    (phy_reset_ack),
        .phy_train_cmd    (phy_train_cmd),
        .phy_train_status (phy_train_status),
        .analog_busy      (analog_busy),
        .lane_error       (lane_error),
        .lane_map         (lane_map),
        .resp_state       (resp_state),
        .cmd_err          (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply a command and count edges until the responder leaves RUN.
    task automatic issue(input logic [7:0] cmd, output logic [7:0] entry_sts, output int lat);
        phy_train_cmd = cmd;
        step();
        lat       = 1;
        entry_sts = phy_train_status;
        while (resp_state == S_RUN && lat < 100) begin
            step();
            lat++;
        end
        if (lat >= 100) check("run_timeout", 32'(lat), 32'd0);
    endtask

    task automatic go_idle();
        phy_train_cmd = 8'h00;
        step();
    endtask

    logic [7:0] entry;
    int         lat;

    initial begin
        rst_n = 1'b0; phy_reset_req = 1'b0; phy_train_cmd = 8'h00;
        analog_busy = 1'b0; lane_error = 8'h00;
        step(); step();
        check("rst_status", 32'(phy_train_status), 32'h00);
        check("rst_lane_map", 32'(lane_map), 32'hFF);
        check("rst_state", 32'(resp_state), 32'(S_RESET));
        check("rst_ack", 32'(phy_reset_ack), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);

        // Bring-up: reset request pulse, then 01..05 in order.
        rst_n = 1'b1; phy_reset_req = 1'b1;
        step();
        check("req_state", 32'(resp_state), 32'(S_RESET));
        phy_reset_req = 1'b0;
        step();
        check("idle_after_req", 32'(resp_state), 32'(S_IDLE));

        issue(8'h01, entry, lat);
        check("sbinit_lat", 32'(lat), 32'd5);
        check("sbinit_ack", 32'(phy_reset_ack), 32'd1);
        issue(8'h02, entry, lat);
        check("mbinit_entry", 32'(entry), 32'h80);
        check("mbinit_lat", 32'(lat), 32'd4);
        check("mbinit_sts", 32'(phy_train_status), 32'h01);
        issue(8'h03, entry, lat);
        check("cal_lat", 32'(lat), 32'd6);
        issue(8'h04, entry, lat);
        check("train_lat", 32'(lat), 32'd7);
        issue(8'h05, entry, lat);
        check("linkinit_lat", 32'(lat), 32'd3);
        check("bringup_sts", 32'(phy_train_status), 32'h0F);
        check("bringup_state", 32'(resp_state), 32'(S_DONE));
        check("bringup_ack_held", 32'(phy_reset_ack), 32'd1);

        // Retrain from fully trained: 00 then 04.
        go_idle();
        check("done_to_idle", 32'(resp_state), 32'(S_IDLE));
        issue(8'h04, entry, lat);
        check("retrain_entry", 32'(entry), 32'h83);
        check("retrain_lat", 32'(lat), 32'd7);
        check("retrain_sts", 32'(phy_train_status), 32'h07);
        go_idle();
        issue(8'h05, entry, lat);
        check("relink_sts", 32'(phy_train_status), 32'h0F);

        // Repair fail: three lanes newly failed exceeds budget of two.
        go_idle();
        lane_error = 8'h0E;
        issue(8'h06, entry, lat);
        check("repfail_lat", 32'(lat), 32'd5);
        check("repfail_sts", 32'(phy_train_status), 32'h2F);
        check("repfail_map", 32'(lane_map), 32'hFF);
        // Repair pass: two lanes dropped.
        go_idle();
        lane_error = 8'h05;
        issue(8'h06, entry, lat);
        lane_error = 8'h00;
        check("reppass_lat", 32'(lat), 32'd5);
        check("reppass_sts", 32'(phy_train_status), 32'h1F);
        check("reppass_map", 32'(lane_map), 32'hFA);

        // Illegal command in DONE.
        phy_train_cmd = 8'h09;
        step();
        check("illegal_err", 32'(cmd_err), 32'd1);
        check("illegal_state", 32'(resp_state), 32'(S_DONE));
        check("illegal_sts", 32'(phy_train_status), 32'h1F);
        go_idle();

        // Stall: busy for three cycles once the CAL timer reaches 2.
        phy_train_cmd = 8'h03;
        step(); step(); step();
        analog_busy = 1'b1;
        step(); step(); step();
        analog_busy = 1'b0;
`ifdef UCIE_PHY_RESP_STALL_LIMIT_EN
        check("stall_state", 32'(resp_state), 32'(S_IDLE));
        check("stall_sts", 32'(phy_train_status), 32'h51);
`else
        lat = 6;
        while (resp_state == S_RUN && lat < 100) begin
            step();
            lat++;
        end
        check("stall_lat", 32'(lat), 32'd9);
        check("stall_sts", 32'(phy_train_status), 32'h13);
`endif
        go_idle();

        // Abort: TRAIN replaced by CAL at timer 3.
        phy_train_cmd = 8'h04;
        step(); step(); step(); step();
        issue(8'h03, entry, lat);
        check("abort_entry", 32'(entry), 32'h91);
        check("abort_lat", 32'(lat), 32'd6);
        check("abort_sts", 32'(phy_train_status), 32'h13);

        // Reset request mid-RUN.
        go_idle();
        phy_train_cmd = 8'h02;
        step(); step();
        phy_reset_req = 1'b1; phy_train_cmd = 8'h00;
        step();
        check("midrun_req_sts", 32'(phy_train_status), 32'h00);
        check("midrun_req_map", 32'(lane_map), 32'hFF);
        check("midrun_req_state", 32'(resp_state), 32'(S_RESET));
        check("midrun_req_ack", 32'(phy_reset_ack), 32'd0);
        phy_reset_req = 1'b0;
        step();
        check("cmd_err_sticky", 32'(cmd_err), 32'd1);
        check("req_release_idle", 32'(resp_state), 32'(S_IDLE));
        rst_n = 1'b0;
        step();
        check("cmd_err_cleared", 32'(cmd_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
